// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and the command-master FSM state type.
package axil_pkg;

    localparam logic [1:0] AXIL_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_EXOKAY = 2'b01;
    localparam logic [1:0] AXIL_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } axil_state_e;

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R) with master and slave views.
interface axil_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport m_axil (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport s_axil (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Runs one AXI4-Lite read or write per accepted UART command and returns a single
// response word; a watchdog converts a stalled transaction into a SLVERR timeout.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_write,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        rsp_timeout,
    axil_if.m_axil                      m_axil
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    axil_state_e                 state_q, state_d;
    logic                        awvalid_q, awvalid_d;
    logic                        wvalid_q, wvalid_d;
    logic                        bready_q, bready_d;
    logic                        arvalid_q, arvalid_d;
    logic                        rready_q, rready_d;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic                        rsp_write_q, rsp_write_d;
    logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                  rsp_resp_q, rsp_resp_d;
    logic                        rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]            wd_cnt_q, wd_cnt_d;
    logic                        busy, wd_expire, aw_done, w_done;

    assign cmd_ready = (state_q == IDLE) && !areset;

    assign busy      = (state_q == WR) || (state_q == WR_RESP) ||
                       (state_q == RD_ADDR) || (state_q == RD_DATA);
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == CNT_LAST);
    assign aw_done   = !awvalid_q || m_axil.awready;
    assign w_done    = !wvalid_q || m_axil.wready;

    always_comb begin
        state_d       = state_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_cnt_d      = wd_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    wd_cnt_d    = '0;
                    rsp_write_d = cmd_write;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR: begin
                if (awvalid_q && m_axil.awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axil.wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axil.bvalid && bready_q) begin
                    bready_d      = 1'b0;
                    rsp_resp_d    = m_axil.bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && m_axil.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil.rvalid && rready_q) begin
                    rready_d      = 1'b0;
                    rsp_rdata_d   = m_axil.rdata;
                    rsp_resp_d    = m_axil.rresp;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog overrides any handshake landing on the expiry cycle.
        if (busy && (TIMEOUT_CYCLES != 0)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            if (wd_expire) begin
                awvalid_d     = 1'b0;
                wvalid_d      = 1'b0;
                bready_d      = 1'b0;
                arvalid_d     = 1'b0;
                rready_d      = 1'b0;
                rsp_resp_d    = AXIL_SLVERR;
                rsp_rdata_d   = '0;
                rsp_timeout_d = 1'b1;
                rsp_valid_d   = 1'b1;
                state_d       = RESP;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= IDLE;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end

    assign m_axil.awvalid = awvalid_q;
    assign m_axil.awaddr  = awaddr_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.araddr  = araddr_q;
    assign m_axil.rready  = rready_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed and random transactions against a
// delay-driven slave, with per-cycle expectations derived from handshake delays.
module tb_axil_cmd_master;
    import axil_pkg::*;

    localparam int T = 16;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_cmd_master #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .m_axil      (bus.m_axil)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit in_win(input int unsigned c, input int unsigned lo, input int unsigned hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic slave_idle();
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
    endtask

    // d_a: AW (write) or AR (read) ready delay; d_w: W ready delay;
    // d_x: B/R valid delay after the master raises bready/rready.
    task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input int unsigned d_a, input int unsigned d_w, input int unsigned d_x,
                           input logic [31:0] rd, input logic [1:0] rr, input int unsigned hold);
        int unsigned done_c, lim, rsp_c, last_c, x_first, rsp_first, addr_end;
        bit          to;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic [6:0]  e_ctl, o_ctl;

        addr_end = wr ? ((d_a > d_w) ? d_a : d_w) : d_a;
        done_c   = 2 + addr_end + d_x;
        to       = (done_c >= T);
        lim      = to ? T : done_c;
        rsp_c    = to ? T + 1 : done_c + 1;
        last_c   = rsp_c + hold + 1;
        e_resp   = to ? AXIL_SLVERR : rr;
        e_rdata  = (to || wr) ? 32'h0 : rd;
        x_first  = 0;
        rsp_first = 0;

        @(negedge aclk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        check({tag, "/cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
        @(posedge aclk);

        for (int unsigned c = 1; c <= last_c; c++) begin
            @(negedge aclk);
            if (c == 1) begin
                cmd_valid = 1'b0;
                cmd_write = 1'($urandom);
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
                cmd_wstrb = 4'($urandom);
            end
            e_ctl = { wr  && in_win(c, 1, umin(1 + d_a, lim)),
                      wr  && in_win(c, 1, umin(1 + d_w, lim)),
                      wr  && in_win(c, 2 + addr_end, lim),
                      !wr && in_win(c, 1, umin(1 + d_a, lim)),
                      !wr && in_win(c, 2 + addr_end, lim),
                      in_win(c, rsp_c, rsp_c + hold),
                      (c == last_c) };
            o_ctl = {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rsp_valid, cmd_ready};
            check($sformatf("%s/ctl@%0d", tag, c), 64'(o_ctl), 64'(e_ctl));
            if (bus.awvalid) check($sformatf("%s/awaddr@%0d", tag, c), 64'(bus.awaddr), 64'(addr));
            if (bus.wvalid)  check($sformatf("%s/wdata@%0d", tag, c), 64'({bus.wdata, bus.wstrb}), 64'({wd, ws}));
            if (bus.arvalid) check($sformatf("%s/araddr@%0d", tag, c), 64'(bus.araddr), 64'(addr));
            if (rsp_valid)
                check($sformatf("%s/rsp@%0d", tag, c),
                      64'({rsp_write, rsp_timeout, rsp_resp, rsp_rdata}),
                      64'({wr, to, e_resp, e_rdata}));

            bus.awready = bus.awvalid && (c >= 1 + d_a);
            bus.wready  = bus.wvalid  && (c >= 1 + d_w);
            bus.arready = bus.arvalid && (c >= 1 + d_a);
            if ((bus.bready || bus.rready) && x_first == 0) x_first = c;
            bus.bvalid = bus.bready && (c >= x_first + d_x);
            bus.bresp  = rr;
            bus.rvalid = bus.rready && (c >= x_first + d_x);
            bus.rdata  = rd;
            bus.rresp  = rr;
            if (rsp_valid && rsp_first == 0) rsp_first = c;
            rsp_ready = rsp_valid && (c >= rsp_first + hold);
            @(posedge aclk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed hang, expected completion");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        areset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        slave_idle();

        repeat (3) @(negedge aclk);
        check("reset/ctl", 64'({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, rsp_valid, cmd_ready}), 64'd0);
        check("reset/addr", 64'({bus.awaddr, bus.araddr}), 64'd0);
        check("reset/wdata", 64'({bus.wdata, bus.wstrb}), 64'd0);
        check("reset/rsp", 64'({rsp_rdata, rsp_resp, rsp_timeout}), 64'd0);
        areset = 1'b0;
        #1 check("reset/cmd_ready_release", 64'(cmd_ready), 64'd1);

        run_txn("wr_zero_wait", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h0, AXIL_OKAY, 0);
        run_txn("wr_w_before_aw", 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 3, 0, 0, 32'h0, AXIL_OKAY, 1);
        run_txn("rd_slow_r", 1'b0, 32'h0000_0030, 32'h0, 4'h0, 0, 0, 5, 32'h1234_5678, AXIL_OKAY, 3);
        run_txn("rd_decerr", 1'b0, 32'hFFFF_0000, 32'h0, 4'h0, 1, 0, 1, 32'hA5A5_5A5A, AXIL_DECERR, 0);
        run_txn("wr_exokay", 1'b1, 32'h0000_0044, 32'h0BAD_CAFE, 4'h9, 1, 2, 0, 32'h0, AXIL_EXOKAY, 0);
        run_txn("wr_timeout", 1'b1, 32'h0000_0050, 32'h1111_2222, 4'hF, 1000, 0, 0, 32'h0, AXIL_OKAY, 1);
        run_txn("rd_timeout", 1'b0, 32'h0000_0060, 32'h0, 4'h0, 2, 0, 1000, 32'h7777_8888, AXIL_OKAY, 0);
        run_txn("wr_after_to", 1'b1, 32'h0000_0070, 32'h3333_4444, 4'hC, 0, 1, 2, 32'h0, AXIL_SLVERR, 2);

        // Reset pulsed while the read is waiting for R data.
        @(negedge aclk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0080;
        check("rst_mid/cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge aclk);
        @(negedge aclk);
        cmd_valid = 1'b0;
        check("rst_mid/arvalid", 64'(bus.arvalid), 64'd1);
        bus.arready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        bus.arready = 1'b0;
        check("rst_mid/rready", 64'(bus.rready), 64'd1);
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("rst_mid/ctl_in_reset", 64'({bus.arvalid, bus.rready, rsp_valid, cmd_ready}), 64'd0);
        areset = 1'b0;
        #1 check("rst_mid/cmd_ready_after", 64'(cmd_ready), 64'd1);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hBADD_A7A0;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk);
            @(negedge aclk);
            check($sformatf("rst_mid/no_rsp%0d", i), 64'({rsp_valid, bus.rready, cmd_ready}), 64'd1);
        end
        slave_idle();

        run_txn("wr_after_reset", 1'b1, 32'h0000_0090, 32'h5555_AAAA, 4'h1, 0, 0, 1, 32'h0, AXIL_OKAY, 0);

        for (int n = 0; n < 30; n++) begin
            bit          wr;
            int unsigned d_a, d_w, d_x;
            wr  = 1'($urandom);
            d_a = $urandom_range(0, 4);
            d_w = $urandom_range(0, 4);
            d_x = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) d_x = $urandom_range(5, 20);
            run_txn($sformatf("rand%0d", n), wr, $urandom, $urandom, 4'($urandom),
                    d_a, d_w, d_x, $urandom, 2'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Upstream stage that drives the AXI-Lite master side of the UART-to-AXI bridge.
- Accepts one decoded command at a time from the UART command parser: read or write, address, data and strobes.
- Runs the corresponding single AXI4-Lite transaction on an axil_if in m_axil modport, then returns one response word to the parser/reply encoder.
- One outstanding transaction maximum; includes a watchdog so a dead slave cannot hang the UART link.

Parameters:
- AXI_DATA_WIDTH, 32, data width; must match the connected axil_if.
- AXI_ADDR_WIDTH, 32, address width; must match the connected axil_if.
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction before abort; 0 disables the watchdog.

Ports:
- aclk  input  1  sole clock.
- areset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when high together with cmd_valid.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  AXI_ADDR_WIDTH  byte address.
- cmd_wdata  input  AXI_DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  input  AXI_DATA_WIDTH/8  write strobes; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_write  output  1  echo of cmd_write.
- rsp_rdata  output  AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  output  2  BRESP/RRESP, or SLVERR on timeout.
- rsp_timeout  output  1  transaction aborted by the watchdog.
- m_axil  interface  axil_if.m_axil  AXI-Lite master channels (AW, W, B, AR, R).

Behaviour:
- Clocking and reset: single clock aclk; areset is synchronous, active-high.
- Reset values: state IDLE; awvalid, wvalid, bready, arvalid, rready and rsp_valid are 0; awaddr, araddr, wdata, wstrb, rsp_rdata and rsp_resp are 0; rsp_timeout is 0. cmd_ready is forced 0 while areset is high.
- All AXI and rsp outputs are registered. cmd_ready is combinational: it equals (state == IDLE) && !areset.
- State IDLE, on cmd_valid && cmd_ready:
  - Capture all cmd_* fields.
  - Write: go to WR, set awvalid=1 and wvalid=1 (visible the next cycle).
  - Read: go to RD_ADDR, set arvalid=1.
- State WR:
  - awvalid and wvalid drop independently on their own handshakes.
  - Address and data stay stable while the corresponding valid is high.
  - When both handshakes are complete (including in the same cycle), go to WR_RESP with bready=1.
- State WR_RESP: on bvalid && bready, latch bresp, drop bready, set rsp_valid=1, go to RESP.
- State RD_ADDR: on arvalid && arready, drop arvalid, set rready=1, go to RD_DATA.
- State RD_DATA: on rvalid && rready, latch rdata and rresp, drop rready, set rsp_valid=1, go to RESP.
- State RESP: hold rsp_* stable until rsp_ready is high, then clear rsp_valid and return to IDLE. A new command can be accepted the cycle after.
- Minimum latency, zero-wait slave: command accepted at cycle 0; AW/W/AR valid at cycle 1; B or R handshake at cycle 2; rsp_valid at cycle 3.
- Watchdog:
  - Counter clears on command acceptance and increments every cycle in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When the count reaches TIMEOUT_CYCLES (nonzero), all master valids and readies drop and the FSM goes to RESP with rsp_resp=2'b10 and rsp_timeout=1.
  - This knowingly abandons the AXI transaction and exists for debug recovery only. Late bvalid or rvalid after abort is ignored because bready and rready stay 0.
- areset asserted in any state returns to IDLE and reset values on the next edge. No response is produced for the interrupted command.
- Responses other than OKAY (EXOKAY, SLVERR, DECERR) are passed through unchanged, with rsp_timeout=0.

Decomposition:
- Shared package axil_pkg holds:
  - resp codes: AXIL_OKAY=2'b00, AXIL_EXOKAY=2'b01, AXIL_SLVERR=2'b10, AXIL_DECERR=2'b11;
  - state enum: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- No sub-module is needed; the watchdog is an inline counter.

Test Plan:
- Write, zero-wait slave: addr 0x0000_0010, data 0xDEADBEEF, wstrb 0xF -> awvalid and wvalid at cycle 1; rsp_valid at cycle 3 with rsp_resp=00, rsp_write=1, rsp_rdata=0.
- W before AW: wready at cycle 1, awready at cycle 4 -> wvalid low from cycle 2; awvalid held with awaddr stable through cycle 4; exactly one response.
- Read with rvalid delayed 5 cycles, rdata 0x12345678, rresp 00, and rsp_ready held low 3 cycles -> rsp_rdata=0x12345678 held stable; cmd_ready=0 until the rsp handshake.
- Read returning DECERR (rresp=11) -> rsp_resp=11, rsp_timeout=0; next command accepted normally.
- TIMEOUT_CYCLES=16 and awready never asserted -> 16 cycles after acceptance all valids drop; rsp_resp=10, rsp_timeout=1.
- areset pulsed in RD_DATA -> next cycle arvalid, rready and rsp_valid are 0; cmd_ready=1 the cycle after areset deasserts; no response emitted.
